spi_reg_responder: RTL



---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_reg_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } spi_state_t;

  localparam int CMD_RD_BIT = 7;
  localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall detection
// taken from the last two stages.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // s[0] is the newest sample, s[STAGES-1] the oldest.
  logic [STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= {STAGES{RST_VAL}};
    end else begin
      s <= {s[STAGES-2:0], din};
    end
  end

  assign level = s[STAGES-1];
  assign rise  = s[STAGES-2] & ~s[STAGES-1];
  assign fall  = ~s[STAGES-2] & s[STAGES-1];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI responder with an 8-bit register file, burst read/write and host port.
// Optional macro SPI_MISO_TRISTATE_EN releases miso (1'bz) while deselected.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // cs resets to 0 so a frame already in progress at reset shows no falling
  // edge; the responder waits for cs to go high and fall again.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t        state;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [6:0]        tx_shift;
  logic [ADDR_W-1:0] addr;
  logic              miso_q;
  logic [7:0]        regs [NUM_REGS];

  logic [SPI_BYTE_W-1:0] rx_byte;
  logic                  byte_done;
  logic                  spi_we;
  logic [ADDR_W-1:0]     addr_inc;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [ADDR_W-1:0]     load_addr;
  logic [7:0]            load_val;
  logic [7:0]            host_next;

  assign rx_byte   = {rx_shift, mosi_level};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE) && !cs_rise;
  assign spi_we    = byte_done && (state == WR);
  assign addr_inc  = (addr == ADDR_W'(NUM_REGS - 1)) ? '0 : addr + ADDR_W'(1);
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign load_addr = (state == CMD) ? cmd_addr : addr_inc;
  assign load_val  = regs[load_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 7'd0;
      addr      <= '0;
      miso_q    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_rise) begin
        // Any partial byte is dropped here without a commit.
        state   <= IDLE;
        bit_cnt <= 3'd0;
        miso_q  <= 1'b0;
        busy    <= 1'b0;
      end else if (state == IDLE) begin
        if (cs_fall) begin
          state   <= CMD;
          bit_cnt <= 3'd0;
          miso_q  <= 1'b0;
          busy    <= 1'b1;
        end
      end else begin
        if (sck_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte[6:0];
        end
        if (byte_done) begin
          if (state == CMD) begin
            addr <= cmd_addr;
            if (rx_byte[CMD_RD_BIT]) begin
              state    <= RD;
              miso_q   <= load_val[7];
              tx_shift <= load_val[6:0];
            end else begin
              state <= WR;
            end
          end else if (state == RD) begin
            addr     <= addr_inc;
            miso_q   <= load_val[7];
            tx_shift <= load_val[6:0];
          end else begin
            wr_strobe <= 1'b1;
            wr_addr   <= addr;
            wr_data   <= rx_byte;
            addr      <= addr_inc;
          end
        end else if (sck_fall && (bit_cnt != 3'd0) && (state == RD)) begin
          // The falling edge right after a byte boundary keeps the freshly
          // loaded bit 7, which makes mode 0 and mode 3 behave the same.
          miso_q   <= tx_shift[6];
          tx_shift <= {tx_shift[5:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    host_next = regs[host_addr];
    if (host_we) host_next = host_wdata;
    if (spi_we && (addr == host_addr)) host_next = rx_byte;
  end

  // On an address collision the SPI write is applied and the host write dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
      host_rdata <= 8'd0;
    end else begin
      if (spi_we) regs[addr] <= rx_byte;
      if (host_we && !(spi_we && (addr == host_addr))) regs[host_addr] <= host_wdata;
      host_rdata <= host_next;
    end
  end

`ifdef SPI_MISO_TRISTATE_EN
  assign miso = (rst || cs_level) ? 1'bz : miso_q;
`else
  logic cs_level_unused;
  assign cs_level_unused = cs_level;
  assign miso = miso_q;
`endif

endmodule
